// File: rtl/imem_loader.sv
// Instruction-memory loader.
// Assembles a stream of serial bytes into little-endian 32-bit words and writes
// them into consecutive instruction-memory addresses. The word count is taken
// when a session starts and is limited to the memory depth.
module imem_loader #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CntW = ADDR_W + 1;
  localparam logic [ADDR_W:0] DepthCnt = CntW'(DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StWrite,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;   // words to write this session
  logic [ADDR_W:0]   words_q, words_d;   // words written so far
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       asm_q, asm_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    words_d    = words_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    byte_ready = 1'b0;
    we         = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        done = (state_q == StDone);
        if (start) begin
          if (word_count == '0) begin
            state_d = StDone;
          end else begin
            state_d    = StRecv;
            count_d    = (word_count > DepthCnt) ? DepthCnt : word_count;
            words_d    = '0;
            byte_cnt_d = '0;
            asm_d      = '0;
            waddr_d    = '0;
          end
        end
      end
      StRecv: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) begin
          asm_d[byte_cnt_q*8 +: 8] = byte_in;
          byte_cnt_d               = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // Word is complete: present it on wdata for the write cycle.
            wdata_d = {byte_in, asm_q[23:0]};
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        we      = 1'b1;
        busy    = 1'b1;
        words_d = words_q + CntW'(1);
        if (words_d == count_q) begin
          state_d = StDone;
        end else begin
          state_d    = StRecv;
          waddr_d    = waddr_q + ADDR_W'(1);
          byte_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      count_q    <= '0;
      words_q    <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      words_q    <= words_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign waddr = waddr_q;
  assign wdata = wdata_q;

endmodule
